dice_game_multi: RTL

Multi-player, parametrised craps controller: the next generation of the team's single-player dice game FSM. It accepts an externally generated dice sum and a roll button, and resolves natural/craps/point rounds. It also rotates turns among N players, keeps saturating per-player win scores and ends the match when a player reaches a target score. Optionally, it enforces a point-phase roll limit. It sits between the dice-sum datapath (counters/adder) and the display/score logic.

---
 rtl/dice_game_multi.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/dice_game_multi.sv
// rtl/dice_game_multi.sv - multi-player craps round/turn/score controller
// Optional point-phase roll limit enabled by defining DICE_ROLL_LIMIT_EN.
module dice_game_multi #(
    parameter  int SUM_W           = 4,
    parameter  int N_PLAYERS       = 2,
    parameter  int SCORE_W         = 8,
    parameter  int WIN_TARGET      = 5,
    parameter  int MAX_POINT_ROLLS = 8,
    localparam int PW              = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1,
    localparam int CNT_W           = $clog2(MAX_POINT_ROLLS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SUM_W-1:0]             sum_i,
    input  logic                         rb_i,
    input  logic                         new_round_i,
    input  logic                         clr_scores_i,
    output logic                         roll_o,
    output logic                         win_o,
    output logic                         lose_o,
    output logic                         match_over_o,
    output logic [PW-1:0]                player_o,
    output logic [SUM_W-1:0]             point_o,
    output logic                         point_valid_o,
    output logic [CNT_W-1:0]             roll_cnt_o,
    output logic [N_PLAYERS*SCORE_W-1:0] scores_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_COME, S_PWAIT, S_PROLL, S_WIN, S_LOSE, S_OVER
    } state_t;

    localparam logic [SUM_W-1:0]   C_2      = SUM_W'(2);
    localparam logic [SUM_W-1:0]   C_3      = SUM_W'(3);
    localparam logic [SUM_W-1:0]   C_7      = SUM_W'(7);
    localparam logic [SUM_W-1:0]   C_11     = SUM_W'(11);
    localparam logic [SUM_W-1:0]   C_12     = SUM_W'(12);
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCR_MAX  = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] TARGET   = SCORE_W'(WIN_TARGET);
    localparam logic [PW-1:0]      LAST_PLR = PW'(N_PLAYERS - 1);

    state_t                       r_state;
    state_t                       w_state_next;
    logic [PW-1:0]                r_player;
    logic [SUM_W-1:0]             r_point;
    logic [CNT_W-1:0]             r_roll_cnt;
    logic [N_PLAYERS*SCORE_W-1:0] r_scores;

    logic                         w_d7;
    logic                         w_d711;
    logic                         w_d2312;
    logic                         w_limit;
    logic [CNT_W-1:0]             w_cnt_next;
    logic [SCORE_W-1:0]           w_cur_score;
    logic [SCORE_W-1:0]           w_score_next;
    logic [PW-1:0]                w_player_next;
    logic                         w_clear;
    logic                         w_capture;
    logic                         w_cnt_inc;
    logic                         w_score_inc;
    logic                         w_advance;

    assign w_d7          = (sum_i == C_7);
    assign w_d711        = w_d7 || (sum_i == C_11);
    assign w_d2312       = (sum_i == C_2) || (sum_i == C_3) || (sum_i == C_12);
    assign w_cnt_next    = (r_roll_cnt == CNT_MAX) ? r_roll_cnt : r_roll_cnt + 1'b1;
    assign w_cur_score   = r_scores[int'(r_player)*SCORE_W +: SCORE_W];
    assign w_score_next  = (w_cur_score == SCR_MAX) ? w_cur_score : w_cur_score + 1'b1;
    assign w_player_next = (r_player == LAST_PLR) ? '0 : r_player + 1'b1;

`ifdef DICE_ROLL_LIMIT_EN
    assign w_limit = (w_cnt_next == CNT_W'(MAX_POINT_ROLLS));
`else
    assign w_limit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_capture    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_score_inc  = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clr_scores_i) begin
                    w_clear = 1'b1;
                end else if (rb_i) begin
                    w_state_next = S_COME;
                end
            end
            S_COME: begin
                if (!rb_i) begin
                    if (w_d711) begin
                        w_state_next = S_WIN;
                        w_score_inc  = 1'b1;
                    end else if (w_d2312) begin
                        w_state_next = S_LOSE;
                    end else begin
                        w_state_next = S_PWAIT;
                        w_capture    = 1'b1;
                    end
                end
            end
            S_PWAIT: begin
                if (rb_i) begin
                    w_state_next = S_PROLL;
                end
            end
            S_PROLL: begin
                if (!rb_i) begin
                    w_cnt_inc = 1'b1;
                    // Matching the point outranks a 7 and the roll limit
                    if (sum_i == r_point) begin
                        w_state_next = S_WIN;
                        w_score_inc  = 1'b1;
                    end else if (w_d7 || w_limit) begin
                        w_state_next = S_LOSE;
                    end else begin
                        w_state_next = S_PWAIT;
                    end
                end
            end
            S_WIN: begin
                if (clr_scores_i) begin
                    w_clear = 1'b1;
                end else if (new_round_i) begin
                    if (w_cur_score == TARGET) begin
                        w_state_next = S_OVER;
                    end else begin
                        w_state_next = S_IDLE;
                        w_advance    = 1'b1;
                    end
                end
            end
            S_LOSE: begin
                if (clr_scores_i) begin
                    w_clear = 1'b1;
                end else if (new_round_i) begin
                    w_state_next = S_IDLE;
                    w_advance    = 1'b1;
                end
            end
            S_OVER: begin
                if (clr_scores_i) begin
                    w_clear = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_clear) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_player   <= '0;
            r_point    <= '0;
            r_roll_cnt <= '0;
            r_scores   <= '0;
        end else if (w_clear) begin
            r_player   <= '0;
            r_roll_cnt <= '0;
            r_scores   <= '0;
        end else begin
            if (w_capture) begin
                r_point    <= sum_i;
                r_roll_cnt <= '0;
            end
            if (w_cnt_inc) begin
                r_roll_cnt <= w_cnt_next;
            end
            if (w_score_inc) begin
                r_scores[int'(r_player)*SCORE_W +: SCORE_W] <= w_score_next;
            end
            if (w_advance) begin
                r_player <= w_player_next;
            end
        end
    end

    assign roll_o        = rb_i && ((r_state == S_COME) || (r_state == S_PROLL));
    assign win_o         = (r_state == S_WIN);
    assign lose_o        = (r_state == S_LOSE);
    assign match_over_o  = (r_state == S_OVER);
    assign point_valid_o = (r_state == S_PWAIT) || (r_state == S_PROLL);
    assign player_o      = r_player;
    assign point_o       = r_point;
    assign roll_cnt_o    = r_roll_cnt;
    assign scores_o      = r_scores;

endmodule
